radar_pulse_sched: RTL

- Sequences the DDS radar waveform datapath using the wave, mode, frequency, pulse-time and duty parameters produced by the key/parameter controller.
- Shadows those parameters and applies them only at pulse-repetition boundaries, so a pulse is never modified mid-flight.
- Converts F to a 32-bit DDS frequency word.
- Drives DDS enable/pulse gating for continuous, single-pulse, pulse-train and burst modes.

---
 rtl/radar_pulse_sched.sv | 115 +++++++++++
 1 files changed

// File: rtl/radar_pulse_sched.sv
// radar_pulse_sched: DDS radar pulse sequencer that applies shadowed parameters only at PRI boundaries.
// Define RADAR_PHASE_RST_EN to drive phase_rst in every LOAD cycle (coherent pulses); otherwise it is tied low.
module radar_pulse_sched #(
   parameter int          CLK_MHZ = 50,
   parameter logic [31:0] FW_STEP = 32'd8589935,
   parameter int          BURST_N = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        param_upd,
   input  logic [5:0]  wave_sel_i,
   input  logic [3:0]  mode_sel_i,
   input  logic [8:0]  F_i,
   input  logic [10:0] T_i,
   input  logic [6:0]  Z_i,
   output logic        busy,
   output logic        dds_en,
   output logic        pulse_on,
   output logic        frame_start,
   output logic [31:0] fword,
   output logic [5:0]  wave_sel_o,
   output logic [15:0] pulse_cnt,
   output logic        phase_rst
);
   localparam int TW = 24;
   typedef enum logic [2:0] {IDLE, LOAD, PULSE, GAP, CW} state_t;
   state_t state, state_n;
   logic [TW-1:0] timer, timer_n, pulse_len_s, pulse_len_a, gap_len_a;
   logic [5:0] wave_s;
   logic [3:0] mode_s, mode_a;
   logic [8:0] f_s;
   logic [10:0] t_s, t_a;
   logic [6:0] z_s, z_a;
   logic pending;
   assign pulse_len_s = TW'(t_s) * TW'(CLK_MHZ);
   assign pulse_len_a = TW'(t_a) * TW'(CLK_MHZ);
   // Loaded at the last PULSE cycle so GAP lasts T*(Z-1)*CLK_MHZ-1 cycles
   assign gap_len_a = TW'(t_a) * TW'(z_a - 7'd1) * TW'(CLK_MHZ) - TW'(2);
   assign busy = state != IDLE;
   assign pulse_on = state == PULSE;
   assign dds_en = state == PULSE || state == CW;
   assign frame_start = pulse_on && timer == pulse_len_a - TW'(1);
`ifdef RADAR_PHASE_RST_EN
   assign phase_rst = state == LOAD;
`else
   assign phase_rst = 1'b0;
`endif
   always_comb begin
      state_n = state;
      timer_n = timer;
      if (stop) state_n = IDLE;
      else begin
         case (state)
            IDLE:  state_n = start ? LOAD : IDLE;
            LOAD: begin
               timer_n = pulse_len_s - TW'(1);
               state_n = mode_s == 4'b0001 ? CW : PULSE;
            end
            PULSE: begin
               timer_n = timer == '0 ? gap_len_a : timer - TW'(1);
               state_n = timer == '0 ? GAP : PULSE;
            end
            GAP: begin
               timer_n = timer - TW'(1);
               if (timer == '0)
                  state_n = (mode_a == 4'b0100 || (mode_a == 4'b1000 && pulse_cnt < 16'(BURST_N))) ? LOAD : IDLE;
            end
            CW:      state_n = pending ? LOAD : CW;
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= '0;
         wave_s     <= 6'b000001;
         mode_s     <= 4'b0001;
         f_s        <= 9'd1;
         t_s        <= 11'd10;
         z_s        <= 7'd2;
         pending    <= 1'b0;
         wave_sel_o <= 6'b000001;
         fword      <= FW_STEP;
         mode_a     <= 4'b0001;
         t_a        <= 11'd10;
         z_a        <= 7'd2;
         pulse_cnt  <= '0;
      end else begin
         state <= state_n;
         timer <= timer_n;
         if (state == LOAD) begin
            wave_sel_o <= wave_s;
            mode_a     <= mode_s;
            t_a        <= t_s;
            z_a        <= z_s;
            fword      <= 32'(f_s) * FW_STEP;
            pending    <= 1'b0;
         end
         // A capture in the LOAD cycle re-arms pending for the next boundary
         if (param_upd) begin
            wave_s  <= $onehot(wave_sel_i) ? wave_sel_i : wave_s;
            mode_s  <= $onehot(mode_sel_i) ? mode_sel_i : mode_s;
            f_s     <= F_i == '0 ? 9'd1 : F_i;
            t_s     <= T_i == '0 ? 11'd10 : T_i;
            z_s     <= Z_i < 7'd2 ? 7'd2 : Z_i;
            pending <= 1'b1;
         end
         if (state == IDLE && start && !stop) pulse_cnt <= '0;
         else if (frame_start && pulse_cnt != 16'hFFFF) pulse_cnt <= pulse_cnt + 16'd1;
      end
   end
endmodule
